// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: takes one execute result at a time, runs an optional
// data-memory load or store, and issues a single-cycle register-file write strobe.
module mem_wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [1:0]           ex_op,
  input  logic [4:0]           ex_rd,
  input  logic [WORD_SIZE-1:0] ex_result,
  input  logic [WORD_SIZE-1:0] ex_store_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_en,
  output logic [4:0]           wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 mem_err,
  output logic                 busy
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign ex_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          case (ex_op)
            OP_ALU:            state_next = WB;
            OP_LOAD, OP_STORE: state_next = ACCESS;
            default:           state_next = IDLE;
          endcase
        end
      end
      ACCESS: begin
        // An ack in the timeout cycle still completes the access.
        if (mem_ack)          state_next = mem_we ? IDLE : WB;
        else if (timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs; wb_en and mem_err default low so they pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mem_err   <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            case (ex_op)
              OP_ALU: begin
                wb_rd   <= ex_rd;
                wb_data <= ex_result;
                wb_en   <= 1'b1;
              end
              OP_LOAD, OP_STORE: begin
                wb_rd    <= ex_rd;
                mem_req  <= 1'b1;
                mem_we   <= ex_op[0];
                mem_addr <= ex_result[ADDR_W-1:0];
                wait_cnt <= '0;
                if (ex_op == OP_STORE) mem_wdata <= ex_store_data;
              end
              default: ;
            endcase
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              wb_data <= mem_rdata;
              wb_en   <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random transactions, each checked
// cycle by cycle against a transaction-level schedule derived from the stage's timing rules.
module tb_mem_wb_stage;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_W    = 8;
  localparam int TIMEOUT   = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [1:0]           ex_op;
  logic [4:0]           ex_rd;
  logic [WORD_SIZE-1:0] ex_result;
  logic [WORD_SIZE-1:0] ex_store_data;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;
  logic                 wb_en;
  logic [4:0]           wb_rd;
  logic [WORD_SIZE-1:0] wb_data;
  logic                 mem_err;
  logic                 busy;

  int n_total = 0;
  int n_pass  = 0;

  // Architectural view of the writeback registers.
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;

  mem_wb_stage #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_err(mem_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer plus every cycle until the stage is ready again. ack_k is the ACCESS
  // cycle carrying mem_ack (1-based); 0 or anything beyond TIMEOUT means no ack at all.
  task automatic txn(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] res,
                     input logic [31:0] sd, input logic [31:0] rdata, input int ack_k);
    bit is_mem, acked, exp_req, exp_wb, exp_err, exp_rdy;
    int last, n;
    is_mem = op[1];
    acked  = is_mem && ack_k >= 1 && ack_k <= TIMEOUT;
    last   = !is_mem ? 0 : (acked ? ack_k : TIMEOUT);
    if (op == 2'b00)               n = 1;
    else if (op == 2'b01)          n = 2;
    else if (op == 2'b11 && acked) n = last + 1;
    else                           n = last + 2;
    chk("ready_before_transfer", 32'(ex_ready), 32'd1);
    ex_valid      = 1'b1;
    ex_op         = op;
    ex_rd         = rd;
    ex_result     = res;
    ex_store_data = sd;
    mem_ack       = 1'($urandom_range(0, 1));
    mem_rdata     = $urandom;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c == 1 && op != 2'b00) m_rd = rd;
      if (c == 1 && op == 2'b01) m_data = res;
      if (op == 2'b10 && acked && c == last + 1) m_data = rdata;
      exp_req = is_mem && c <= last;
      exp_wb  = (op == 2'b01 && c == 1) || (op == 2'b10 && acked && c == last + 1);
      exp_err = is_mem && !acked && c == last + 1;
      exp_rdy = !(exp_req || exp_wb);
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("wb_en", 32'(wb_en), 32'(exp_wb));
      chk("mem_err", 32'(mem_err), 32'(exp_err));
      chk("ex_ready", 32'(ex_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(!exp_rdy));
      chk("wb_rd", 32'(wb_rd), 32'(m_rd));
      chk("wb_data", wb_data, m_data);
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(op[0]));
        chk("mem_addr", 32'(mem_addr), 32'(res[ADDR_W-1:0]));
        if (op == 2'b11) chk("mem_wdata", mem_wdata, sd);
      end
      // Inputs are free to wander whenever no transfer can happen at the next edge.
      ex_valid      = exp_rdy ? 1'b0 : 1'($urandom_range(0, 1));
      ex_op         = 2'($urandom);
      ex_rd         = 5'($urandom);
      ex_result     = $urandom;
      ex_store_data = $urandom;
      if (acked && c == ack_k) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end else if (exp_req) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  endtask

  initial begin
    int r, k;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    ex_op         = 2'b00;
    ex_rd         = '0;
    ex_result     = '0;
    ex_store_data = '0;
    mem_rdata     = '0;
    mem_ack       = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    tick();

    // ALU writeback, load with ack in ACCESS cycle 3, store with immediate ack
    txn(2'b01, 5'd5, 32'h0000002A, 32'h0, 32'h0, 0);
    txn(2'b10, 5'd9, 32'h00000113, 32'h0, 32'hDEADBEEF, 3);
    txn(2'b11, 5'd3, 32'h00000007, 32'h12345678, 32'h0, 1);
    // Timeout, then ack coinciding with the timeout cycle, then register 0 writeback
    txn(2'b10, 5'd12, 32'hFFFFFF80, 32'h0, 32'h0, 0);
    txn(2'b10, 5'd17, 32'h00000044, 32'h0, 32'hCAFEF00D, TIMEOUT);
    txn(2'b11, 5'd21, 32'h000000FF, 32'hA5A5A5A5, 32'h0, 0);
    txn(2'b01, 5'd0, 32'h80000001, 32'h0, 32'h0, 0);
    txn(2'b00, 5'd30, 32'h11111111, 32'h22222222, 32'h0, 0);

    // Reset in the second ACCESS cycle of a load; a late ack must not write back
    ex_valid  = 1'b1;
    ex_op     = 2'b10;
    ex_rd     = 5'd7;
    ex_result = 32'h00000055;
    mem_ack   = 1'b0;
    tick();
    ex_valid = 1'b0;
    tick();
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    m_rd   = '0;
    m_data = '0;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ack = 1'b0;
      chk("late_ack_wb_en", 32'(wb_en), 32'd0);
      chk("late_ack_busy", 32'(busy), 32'd0);
      chk("late_ack_wb_data", wb_data, 32'd0);
    end
    txn(2'b01, 5'd14, 32'h0BADF00D, 32'h0, 32'h0, 0);

    // Random transactions, mostly short acks with occasional boundary and timeout cases
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      k = $urandom_range(1, 4);
      else if (r < 9) k = TIMEOUT;
      else            k = 0;
      txn(2'($urandom), 5'($urandom), $urandom, $urandom, $urandom, k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the multi-cycle CPU; sits directly downstream of the execute stage.
- Consumes one execute result at a time through a valid/ready handshake.
- Performs a data-memory load or store through a req/ack handshake, or passes an ALU result straight through.
- Emits a one-cycle register-file write strobe (wb_en/wb_rd/wb_data) back to the register file.

Parameters:
- WORD_SIZE, 32: datapath width; matches the CPU-wide word size.
- ADDR_W, 8: data-memory address width; matches the 8-bit address space of instruction memory.
- TIMEOUT, 15: maximum number of cycles in ACCESS waiting for mem_ack before abort; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a result.
- ex_ready  out  1  stage can accept a result this cycle.
- ex_op  in  2  operation code: 00 = none, 01 = ALU writeback, 10 = load, 11 = store.
- ex_rd  in  5  destination register index.
- ex_result  in  WORD_SIZE  ALU result (op 01) or effective address (ops 10/11).
- ex_store_data  in  WORD_SIZE  data to store (op 11).
- mem_req  out  1  data-memory request, held until ack or abort.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  memory address; valid while mem_req=1.
- mem_wdata  out  WORD_SIZE  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  WORD_SIZE  load data; sampled in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle completion from memory.
- wb_en  out  1  register-file write strobe, one cycle wide.
- wb_rd  out  5  register index to write.
- wb_data  out  WORD_SIZE  data to write.
- mem_err  out  1  one-cycle pulse on access timeout.
- busy  out  1  1 whenever state ≠ IDLE.

Behaviour:
- All outputs are registered except ex_ready and busy, which decode the state register.
- Reset (synchronous, rst=1 at a rising edge):
  - state ← IDLE, wait counter ← 0.
  - mem_req, mem_we, wb_en, mem_err ← 0; mem_addr, mem_wdata, wb_rd, wb_data ← 0.
  - Reset overrides everything, including mid-ACCESS. mem_req drops in the cycle after the reset edge, and a pending ack is ignored.
- FSM states: IDLE, ACCESS, WB.
- ex_ready = (state == IDLE). Transfer happens when ex_valid && ex_ready at a rising edge.
- IDLE, on transfer:
  - op 00: consumed; stay in IDLE; no outputs change.
  - op 01: wb_rd ← ex_rd, wb_data ← ex_result, go to WB.
  - op 10: mem_req ← 1, mem_we ← 0, mem_addr ← ex_result[ADDR_W-1:0] (upper bits dropped), go to ACCESS.
  - op 11: same as op 10 but mem_we ← 1 and mem_wdata ← ex_store_data. wb_rd is latched ← ex_rd but never written back.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Wait counter starts at 0 on entry and increments every cycle without ack.
  - mem_ack=1, load: wb_data ← mem_rdata, mem_req ← 0, go to WB.
  - mem_ack=1, store: mem_req ← 0, go to IDLE; no writeback.
  - No ack and counter == TIMEOUT-1: mem_req ← 0, mem_err ← 1 for one cycle, go to IDLE; no writeback.
  - Ack and timeout in the same cycle: ack wins, no mem_err.
- WB: wb_en = 1 for exactly this cycle; next state IDLE. Register index 0 is a normal writable register.
- mem_ack while in IDLE or WB is ignored.
- Latency, transfer edge to wb_en high:
  - ALU op: 1 cycle.
  - Load with ack in the k-th ACCESS cycle: k+1 cycles.
- Throughput:
  - ALU op: one result per 2 cycles.
  - Back-to-back accept: ex_ready returns high in the cycle after WB, or in the cycle after a store ack.
- ex_* inputs are ignored when not transferring. They may change freely while busy=1.

Test Plan:
- Reset, then ex_op=01, rd=5, result=0x0000002A for one transfer → wb_en=1, wb_rd=5, wb_data=0x2A exactly 1 cycle later; ex_ready low for that one cycle only.
- Load: result=0x00000113 → mem_addr=0x13, mem_we=0. Memory acks on the 3rd ACCESS cycle with rdata=0xDEADBEEF → wb_en pulse with rd as given and data 0xDEADBEEF 4 cycles after transfer.
- Store: result=0x07, store_data=0x12345678, immediate ack → mem_we=1, mem_wdata=0x12345678 for one cycle. No wb_en; ex_ready high the following cycle.
- Timeout: TIMEOUT=15, load with no ack → mem_req high exactly 15 cycles, then mem_err pulse; no wb_en; next transfer accepted.
- Edge cases:
  - Ack arriving in the same cycle as timeout → no mem_err; load data written back.
  - Spurious ack while IDLE → no effect.
  - op 00 transfer → no outputs change.
- rst=1 during cycle 2 of ACCESS → mem_req=0 and busy=0 after the edge. A later ack does not produce wb_en. The next ALU op completes normally.
